// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter: instruction fetch (m0) and data (m1) share one
// downstream slave port, with per-transfer stall timeout and a sticky error flag.
module mips_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          FIXED_PRIORITY = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic [31:0] address,
   output logic [31:0] writedata,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [7:0]  stall_q, stall_d;
   logic        err_q, err_d;

   logic        req0, req1;
   logic        pick1;
   logic        g_read, g_write, g_active;
   logic [31:0] g_addr, g_wdata;
   logic [3:0]  g_be;
   logic        timeout;
   logic        g_wait;
   logic [31:0] g_rdata;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         stall_q      <= 8'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         stall_q      <= stall_d;
         err_q        <= err_d;
      end
   end

   // Requester-side view of whichever port currently owns the bus.
   always_comb begin
      if (state_q == GRANT1) begin
         g_read  = m1_read;
         g_write = m1_write;
         g_addr  = m1_address;
         g_wdata = m1_writedata;
         g_be    = m1_byteenable;
      end else begin
         g_read  = m0_read;
         g_write = m0_write;
         g_addr  = m0_address;
         g_wdata = m0_writedata;
         g_be    = m0_byteenable;
      end
      g_active = g_read | g_write;
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      stall_d        = stall_q;
      err_d          = err_q;
      pick1          = 1'b0;
      timeout        = 1'b0;
      g_wait         = 1'b1;
      g_rdata        = 32'd0;
      address        = 32'd0;
      writedata      = 32'd0;
      read           = 1'b0;
      write          = 1'b0;
      byteenable     = 4'd0;
      m0_waitrequest = req0;
      m1_waitrequest = req1;
      m0_readdata    = 32'd0;
      m1_readdata    = 32'd0;

      case (state_q)
         IDLE: begin
            if (req0 && req1)
               pick1 = FIXED_PRIORITY || !last_grant_q;
            else
               pick1 = req1;
            if (req0 || req1) begin
               state_d      = pick1 ? GRANT1 : GRANT0;
               last_grant_d = pick1;
               stall_d      = 8'd0;
            end
         end
         GRANT0, GRANT1: begin
            // Stall cycle that would reach the limit is itself the abort cycle.
            timeout    = g_active && waitrequest && ({1'b0, stall_q} + 9'd1 >= TO_LIM);
            address    = g_addr;
            writedata  = g_wdata;
            byteenable = g_be;
            read       = g_read & ~timeout;
            write      = g_write & ~timeout;
            g_wait     = timeout ? 1'b0 : waitrequest;
            g_rdata    = timeout ? 32'hFFFF_FFFF : readdata;
            if (state_q == GRANT1) begin
               m0_waitrequest = 1'b1;
               m1_waitrequest = g_wait;
               m1_readdata    = g_rdata;
            end else begin
               m1_waitrequest = 1'b1;
               m0_waitrequest = g_wait;
               m0_readdata    = g_rdata;
            end
            if (!g_active || !waitrequest || timeout) begin
               state_d = IDLE;
               err_d   = err_q | timeout;
            end else if (stall_q != 8'hFF) begin
               stall_d = stall_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      bus_error = err_q | timeout;
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: three parameterisations driven in parallel
// (round-robin, fixed priority, short timeout) against vectors and a model.
module tb_mips_bus_arbiter;

   localparam logic [31:0] A0  = 32'hBFC0_0000;
   localparam logic [31:0] A1  = 32'h1000_0010;
   localparam logic [31:0] WD1 = 32'hDEAD_BEEF;
   localparam logic [31:0] RD  = 32'h2402_0005;

   logic        clk, reset;
   logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, readdata;
   logic        m0_read, m0_write, m1_read, m1_write, waitrequest;
   logic [3:0]  m0_byteenable, m1_byteenable;

   logic [2:0]        m0_wr_a, m1_wr_a, rd_a, wr_a, berr_a;
   logic [2:0][31:0]  m0_rd_a, m1_rd_a, addr_a, wdata_a;
   logic [2:0][3:0]   be_a;

   typedef struct packed {
      logic        m0_wr;
      logic [31:0] m0_rd;
      logic        m1_wr;
      logic [31:0] m1_rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic        berr;
   } out_t;

   typedef struct {
      logic r0, w0, r1, w1, wt;
      out_t e;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned p_to[3] = '{255, 255, 4};
   int          p_fp[3] = '{0, 1, 0};
   int          m_own[3];
   int          m_last[3];
   int          m_stall[3];
   bit          m_err[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned TOV = (g == 2) ? 4 : 255;
      localparam bit          FPV = (g == 1);
      mips_bus_arbiter #(.TIMEOUT_CYCLES(TOV), .FIXED_PRIORITY(FPV)) u_dut (
         .clk(clk), .reset(reset),
         .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
         .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
         .m0_waitrequest(m0_wr_a[g]), .m0_readdata(m0_rd_a[g]),
         .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
         .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
         .m1_waitrequest(m1_wr_a[g]), .m1_readdata(m1_rd_a[g]),
         .address(addr_a[g]), .writedata(wdata_a[g]), .read(rd_a[g]), .write(wr_a[g]),
         .byteenable(be_a[g]), .waitrequest(waitrequest), .readdata(readdata),
         .bus_error(berr_a[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic out_t o(logic m0w, logic [31:0] m0r, logic m1w, logic [31:0] m1r,
                              logic [31:0] a, logic [31:0] wd, logic r, logic w,
                              logic [3:0] be, logic be_err);
      out_t x;
      x.m0_wr = m0w; x.m0_rd = m0r; x.m1_wr = m1w; x.m1_rd = m1r;
      x.addr = a; x.wdata = wd; x.rd = r; x.wr = w; x.be = be; x.berr = be_err;
      return x;
   endfunction

   function automatic out_t act(int k);
      return o(m0_wr_a[k], m0_rd_a[k], m1_wr_a[k], m1_rd_a[k], addr_a[k], wdata_a[k],
               rd_a[k], wr_a[k], be_a[k], berr_a[k]);
   endfunction

   // Waitrequest towards an idle requester is a don't-care.
   task automatic chk(string nm, out_t a, out_t e);
      if (!(m0_read | m0_write)) begin a.m0_wr = 1'b0; e.m0_wr = 1'b0; end
      if (!(m1_read | m1_write)) begin a.m1_wr = 1'b0; e.m1_wr = 1'b0; end
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic chk1(string nm, logic [31:0] a, logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_own[k] = -1; m_last[k] = 1; m_stall[k] = 0; m_err[k] = 1'b0;
      end
   endtask

   // One cycle of the arbiter as described by its rules: who owns the bus,
   // what each side sees, and what happens at the coming clock edge.
   task automatic model_cycle(int k, output out_t e);
      bit q0, q1, act_n, to, n_rd, n_wr;
      int pick;
      q0 = m0_read | m0_write;
      q1 = m1_read | m1_write;
      e = o(q0, 0, q1, 0, 0, 0, 0, 0, 0, m_err[k]);
      if (m_own[k] < 0) begin
         if (q0 || q1) begin
            if (q0 && q1) pick = (p_fp[k] != 0) ? 1 : 1 - m_last[k];
            else          pick = q1 ? 1 : 0;
            m_own[k] = pick; m_last[k] = pick; m_stall[k] = 0;
         end
      end else begin
         n_rd  = (m_own[k] == 1) ? m1_read : m0_read;
         n_wr  = (m_own[k] == 1) ? m1_write : m0_write;
         act_n = n_rd || n_wr;
         to    = act_n && waitrequest && (m_stall[k] + 1 >= int'(p_to[k]));
         e.addr  = (m_own[k] == 1) ? m1_address : m0_address;
         e.wdata = (m_own[k] == 1) ? m1_writedata : m0_writedata;
         e.be    = (m_own[k] == 1) ? m1_byteenable : m0_byteenable;
         e.rd    = n_rd && !to;
         e.wr    = n_wr && !to;
         e.berr  = m_err[k] || to;
         if (m_own[k] == 1) begin
            e.m0_wr = 1'b1;
            e.m1_wr = to ? 1'b0 : waitrequest;
            e.m1_rd = to ? 32'hFFFF_FFFF : readdata;
         end else begin
            e.m1_wr = 1'b1;
            e.m0_wr = to ? 1'b0 : waitrequest;
            e.m0_rd = to ? 32'hFFFF_FFFF : readdata;
         end
         if (!act_n || !waitrequest || to) begin
            m_own[k] = -1;
            m_err[k] = m_err[k] || to;
         end else if (m_stall[k] < 255) begin
            m_stall[k]++;
         end
      end
   endtask

   task automatic set_in(logic r0, logic w0, logic r1, logic w1, logic wt);
      m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1; waitrequest = wt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   vec_t vt[7];
   int   gseq_rr[$], gseq_fp[$];
   out_t e;

   initial begin
      reset = 1'b0;
      m0_address = A0; m0_writedata = 32'd0; m0_byteenable = 4'hF;
      m1_address = A1; m1_writedata = WD1;   m1_byteenable = 4'hF;
      readdata = RD;
      set_in(0, 0, 0, 0, 0);
      model_reset();

      // Contention after reset, then a lone fetch.
      vt[0] = '{1, 0, 0, 1, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0)};
      vt[1] = '{1, 0, 0, 1, 0, o(0, RD, 1, 0, A0, 0, 1, 0, 4'hF, 0)};
      vt[2] = '{0, 0, 0, 1, 0, o(0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0)};
      vt[3] = '{0, 0, 0, 1, 0, o(0, 0, 0, RD, A1, WD1, 0, 1, 4'hF, 0)};
      vt[4] = '{1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0)};
      vt[5] = '{1, 0, 0, 0, 0, o(0, RD, 0, 0, A0, 0, 1, 0, 4'hF, 0)};
      vt[6] = '{0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0)};

      #2;
      chk("reset_state", act(0), o(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         set_in(vt[i].r0, vt[i].w0, vt[i].r1, vt[i].w1, vt[i].wt);
         #1;
         chk($sformatf("vec%0d", i), act(0), vt[i].e);
      end

      // Both held through six transfers: grant order per arbitration mode.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         set_in(1, 0, 0, 1, 0);
         #1;
         if (rd_a[0]) gseq_rr.push_back(0);
         if (wr_a[0]) gseq_rr.push_back(1);
         if (rd_a[1]) gseq_fp.push_back(0);
         if (wr_a[1]) gseq_fp.push_back(1);
      end
      chk1("rr_grant_count", gseq_rr.size(), 6);
      for (int i = 0; i < gseq_rr.size() && i < 6; i++)
         chk1($sformatf("rr_grant%0d", i), gseq_rr[i], i % 2);
      for (int i = 0; i < gseq_fp.size() && i < 6; i++)
         chk1($sformatf("fp_grant%0d", i), gseq_fp[i], 1);

      // Three slave stalls, then completion.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         set_in(1, 0, 0, 0, (c >= 1 && c <= 3));
         #1;
         chk1($sformatf("stall_m0_wr%0d", c), m0_wr_a[0], (c <= 3));
         chk1($sformatf("stall_read%0d", c), rd_a[0], (c >= 1));
         chk1($sformatf("stall_berr%0d", c), berr_a[0], 0);
      end
      chk1("stall_rdata", m0_rd_a[0], RD);

      // Stuck slave against TIMEOUT_CYCLES = 4.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c <= 4) set_in(0, 0, 1, 0, 1);
         else        set_in(0, 0, 0, 0, 1);
         #1;
         if (c >= 1 && c <= 3) chk1($sformatf("to_wait%0d", c), m1_wr_a[2], 1);
         if (c <= 3)           chk1($sformatf("to_berr%0d", c), berr_a[2], 0);
         if (c >= 4)           chk1($sformatf("to_sticky%0d", c), berr_a[2], 1);
      end
      do_reset();
      #1;
      chk1("to_berr_cleared", berr_a[2], 0);
      // The abort cycle itself, re-run to observe it in isolation.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         set_in(0, 0, 1, 0, 1);
      end
      #1;
      chk("to_abort_cycle", act(2), o(1, 0, 0, 32'hFFFF_FFFF, A1, WD1, 0, 0, 4'hF, 1));

      // Reset dropped in the middle of a stalled GRANT1 write.
      do_reset();
      @(negedge clk); set_in(0, 0, 0, 1, 1);
      @(negedge clk); #1;
      chk1("mid_grant_write", wr_a[0], 1);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_reset_outputs", act(0), o(0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0));
      @(negedge clk);
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0);
      model_reset();

      // Randomised traffic against the model, all three configurations.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         m0_address    = $urandom;
         m1_address    = $urandom;
         m0_writedata  = $urandom;
         m1_writedata  = $urandom;
         m0_byteenable = 4'($urandom);
         m1_byteenable = 4'($urandom);
         readdata      = $urandom;
         case ($urandom_range(0, 2))
            0:       begin m0_read = 1'b0; m0_write = 1'b0; end
            1:       begin m0_read = 1'b1; m0_write = 1'b0; end
            default: begin m0_read = 1'b0; m0_write = 1'b1; end
         endcase
         case ($urandom_range(0, 2))
            0:       begin m1_read = 1'b0; m1_write = 1'b0; end
            1:       begin m1_read = 1'b1; m1_write = 1'b0; end
            default: begin m1_read = 1'b0; m1_write = 1'b1; end
         endcase
         waitrequest = ($urandom_range(0, 99) < 55);
         #2;
         for (int k = 0; k < 3; k++) begin
            model_cycle(k, e);
            chk($sformatf("rand%0d_dut%0d", i, k), act(k), e);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
